counter_ctrl: RTL and testbench

//  Sequencer/configurator for a WIDTH-bit synchronous up/down counter datapath.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_core.sv | 47 ++++
 rtl/counter_ctrl.sv | 172 +++++++++++++++++
 tb/tb_counter_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared FSM encodings for the counter sequencer
// Contents:
//   STATE_W         width of the controller state register
//   S_IDLE..S_DONE  controller state encodings (IDLE=0 .. DONE=4)
package counter_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] S_RUN  = 3'd2;
  localparam logic [STATE_W-1:0] S_HOLD = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE = 3'd4;

endpackage

// File: rtl/counter_core.sv
// rtl/counter_core.sv - WIDTH-bit synchronous up/down counter with parallel load
// Ports:
//   clk       in   clock, all updates on posedge
//   reset     in   synchronous active-high, clears count
//   load      in   load load_val this cycle (overrides en)
//   load_val  in   value to load
//   en        in   step the count by one this cycle
//   up_dn     in   1 = increment, 0 = decrement (wraps modulo 2**WIDTH)
//   count     out  registered counter value
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      // Natural overflow of the WIDTH-bit sum gives the modulo wrap.
      count_d = up_dn ? (count_q + ONE) : (count_q - ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - sequencer/configurator for an up/down counter datapath
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, stop, pause    run control (priority reset > stop > start > pause)
//   up_dn, auto_reload    direction and reload mode, latched in LOAD
//   load_val, tc_val      start and terminal values, latched in LOAD
//   prescale              tick every prescale+1 cycles, latched in LOAD
//   count                 current counter value (registered)
//   tc_pulse              one-cycle pulse per terminal event (registered)
//   busy                  high in LOAD, RUN, HOLD
//   done                  high in DONE
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  up_dn,
  input  logic                  auto_reload,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      tc_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc_pulse,
  output logic                  busy,
  output logic                  done
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]      cfg_load_q, cfg_load_d;
  logic [WIDTH-1:0]      cfg_tc_q, cfg_tc_d;
  logic [PRESCALE_W-1:0] cfg_pre_q, cfg_pre_d;
  logic                  cfg_up_q, cfg_up_d;
  logic                  cfg_reload_q, cfg_reload_d;
  logic                  tc_pulse_q, tc_pulse_d;

  logic                  core_load;
  logic [WIDTH-1:0]      core_load_val;
  logic                  core_en;

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    cfg_load_d    = cfg_load_q;
    cfg_tc_d      = cfg_tc_q;
    cfg_pre_d     = cfg_pre_q;
    cfg_up_d      = cfg_up_q;
    cfg_reload_d  = cfg_reload_q;
    tc_pulse_d    = 1'b0;
    core_load     = 1'b0;
    core_load_val = cfg_load_q;
    core_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!stop && start) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // Configuration is captured from the live inputs here and only here.
        cfg_load_d    = load_val;
        cfg_tc_d      = tc_val;
        cfg_pre_d     = prescale;
        cfg_up_d      = up_dn;
        cfg_reload_d  = auto_reload;
        core_load     = 1'b1;
        core_load_val = load_val;
        presc_d       = '0;
        state_d       = S_RUN;
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_LOAD;
        end else if (pause) begin
          // Entering HOLD does not advance the prescaler, so the tick phase
          // picks up exactly where it was frozen.
          state_d = S_HOLD;
        end else if (presc_q == cfg_pre_q) begin
          presc_d = '0;
          // Terminal is compared on the tick, so tc_val stays visible for a
          // whole tick period before the event fires.
          if (count == cfg_tc_q) begin
            tc_pulse_d = 1'b1;
            if (cfg_reload_q) begin
              core_load = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            core_en = 1'b1;
          end
        end else begin
          presc_d = presc_q + PRE_ONE;
        end
      end

      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_LOAD;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      cfg_load_q   <= '0;
      cfg_tc_q     <= '0;
      cfg_pre_q    <= '0;
      cfg_up_q     <= 1'b0;
      cfg_reload_q <= 1'b0;
      tc_pulse_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cfg_load_q   <= cfg_load_d;
      cfg_tc_q     <= cfg_tc_d;
      cfg_pre_q    <= cfg_pre_d;
      cfg_up_q     <= cfg_up_d;
      cfg_reload_q <= cfg_reload_d;
      tc_pulse_q   <= tc_pulse_d;
    end
  end

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .load_val (core_load_val),
    .en       (core_en),
    .up_dn    (cfg_up_q),
    .count    (count)
  );

  assign tc_pulse = tc_pulse_q;
  assign busy     = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_HOLD);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl against a behavioural model
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, pause, up_dn, auto_reload;
  logic [3:0] load_val, tc_val, prescale;
  logic [3:0] count;
  logic       tc_pulse, busy, done;

  int n_vec = 0;
  int n_err = 0;

  // Model: run phase, visible count, pulse, cycles spent in current tick period.
  localparam int M_IDLE = 10, M_LOAD = 11, M_RUN = 12, M_HOLD = 13, M_DONE = 14;
  int m_mode  = M_IDLE;
  int m_count = 0;
  int m_pulse = 0;
  int m_wait  = 0;
  int c_load = 0, c_tc = 0, c_pre = 0, c_up = 0, c_rel = 0;

  always #5 clk = ~clk;

  counter_ctrl #(
    .WIDTH(4),
    .PRESCALE_W(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .up_dn       (up_dn),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .tc_val      (tc_val),
    .prescale    (prescale),
    .count       (count),
    .tc_pulse    (tc_pulse),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    m_pulse = 0;
    if (reset) begin
      m_mode = M_IDLE; m_count = 0; m_wait = 0;
      c_load = 0; c_tc = 0; c_pre = 0; c_up = 0; c_rel = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (!stop && start) m_mode = M_LOAD;
        M_LOAD: begin
          c_load = int'(load_val); c_tc = int'(tc_val); c_pre = int'(prescale);
          c_up = int'(up_dn); c_rel = int'(auto_reload);
          m_count = c_load; m_wait = 0; m_mode = M_RUN;
        end
        M_RUN: begin
          if (stop) m_mode = M_IDLE;
          else if (start) m_mode = M_LOAD;
          else if (pause) m_mode = M_HOLD;
          else if (m_wait < c_pre) m_wait++;
          else begin
            m_wait = 0;
            if (m_count == c_tc) begin
              m_pulse = 1;
              if (c_rel != 0) m_count = c_load;
              else m_mode = M_DONE;
            end else begin
              m_count = (c_up != 0) ? (m_count + 1) % 16 : (m_count + 15) % 16;
            end
          end
        end
        M_HOLD: begin
          if (stop) m_mode = M_IDLE;
          else if (start) m_mode = M_LOAD;
          else if (!pause) m_mode = M_RUN;
        end
        default: begin
          if (stop) m_mode = M_IDLE;
          else if (start) m_mode = M_LOAD;
        end
      endcase
    end
  endtask

  // One clock: step the model, take the edge, compare all outputs.
  task automatic apply();
    model_step();
    @(posedge clk);
    #1;
    check("count", int'(count), m_count);
    check("tc_pulse", int'(tc_pulse), m_pulse);
    check("busy", int'(busy), (m_mode == M_LOAD || m_mode == M_RUN || m_mode == M_HOLD) ? 1 : 0);
    check("done", int'(done), (m_mode == M_DONE) ? 1 : 0);
  endtask

  task automatic set_cfg(input int ld, input int tc, input int up, input int pre, input int rel);
    load_val = 4'(ld); tc_val = 4'(tc); up_dn = 1'(up); prescale = 4'(pre); auto_reload = 1'(rel);
  endtask

  initial begin
    int exp3 [12] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    @(negedge clk);
    apply();
    apply();
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pulse", int'(tc_pulse), 0);
    reset = 1'b0;

    // 1: up 3..6, terminal, DONE holding 6
    set_cfg(3, 6, 1, 0, 0); start = 1'b1;
    apply();
    check("t1_busy_load", int'(busy), 1);
    start = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      apply();
      check("t1_seq", int'(count), i);
    end
    apply();
    check("t1_pulse", int'(tc_pulse), 1);
    check("t1_done", int'(done), 1);
    check("t1_busy", int'(busy), 0);
    check("t1_hold", int'(count), 6);
    apply();
    check("t1_pulse_once", int'(tc_pulse), 0);

    // 2: down with wrap 1,0,15,14
    set_cfg(1, 14, 0, 0, 0); start = 1'b1;
    apply();
    start = 1'b0;
    apply(); check("t2_c1", int'(count), 1);
    apply(); check("t2_c0", int'(count), 0);
    apply(); check("t2_c15", int'(count), 15);
    apply(); check("t2_c14", int'(count), 14);
    apply();
    check("t2_pulse", int'(tc_pulse), 1);
    check("t2_done", int'(done), 1);

    // 3: prescale 1 with auto reload
    set_cfg(0, 2, 1, 1, 1); start = 1'b1;
    apply();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      apply();
      check("t3_seq", int'(count), exp3[i]);
      check("t3_pulse", int'(tc_pulse), (i == 6) ? 1 : 0);
    end
    check("t3_busy", int'(busy), 1);
    check("t3_done", int'(done), 0);
    stop = 1'b1; apply(); stop = 1'b0;

    // 4: pause at count 4
    set_cfg(0, 15, 1, 0, 0); start = 1'b1;
    apply();
    start = 1'b0;
    for (int i = 0; i < 5; i++) apply();
    check("t4_pre", int'(count), 4);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply();
      check("t4_frozen", int'(count), 4);
    end
    pause = 1'b0;
    apply(); check("t4_resume", int'(count), 4);
    apply(); check("t4_c5", int'(count), 5);
    apply(); check("t4_c6", int'(count), 6);

    // 5: stop+start together, then reset mid-run
    start = 1'b1; stop = 1'b1;
    apply();
    start = 1'b0; stop = 1'b0;
    check("t5_idle_busy", int'(busy), 0);
    check("t5_idle_count", int'(count), 6);
    set_cfg(0, 15, 1, 0, 0); start = 1'b1;
    apply();
    start = 1'b0;
    for (int i = 0; i < 6; i++) apply();
    check("t5_c5", int'(count), 5);
    reset = 1'b1;
    apply();
    reset = 1'b0;
    check("t5_rst_count", int'(count), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_pulse", int'(tc_pulse), 0);

    // 6: restart in RUN with load 9; cfg changes mid-run ignored
    set_cfg(2, 15, 1, 0, 0); start = 1'b1;
    apply();
    start = 1'b0;
    apply(); apply();
    check("t6_c3", int'(count), 3);
    load_val = 4'd9; start = 1'b1;
    apply();
    check("t6_load_busy", int'(busy), 1);
    start = 1'b0;
    apply();
    check("t6_c9", int'(count), 9);
    set_cfg(1, 10, 0, 3, 1);
    apply(); check("t6_c10", int'(count), 10);
    apply(); check("t6_c11", int'(count), 11);
    stop = 1'b1; apply(); stop = 1'b0;

    // Random phase
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      set_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)));
      apply();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
